// File: rtl/generic_pipe_staging_pkg.sv
// ============================================================================
// Module : generic_pipe_staging_pkg
// Shared sizing helper for the staged pipeline.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package generic_pipe_staging_pkg;

  // Occupancy counter width: enough bits for 0..depth, at least one bit.
  function automatic int occ_width(input int depth);
    if (depth <= 0) return 1;
    return $clog2(depth + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/generic_pipe_stage.sv
// ============================================================================
// Module : generic_pipe_stage
// One pipeline slot: valid flop, enabled data flop and its ready term.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module generic_pipe_stage
  import generic_pipe_staging_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit              COLLAPSE    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             adv,
  input  logic             down_rdy,
  input  logic             up_valid,
  input  logic [WIDTH-1:0] up_data,
  output logic             rdy,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  always_comb begin
    rdy     = COLLAPSE ? (~valid_q | down_rdy) : adv;
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (rdy) begin
      valid_d = up_valid;
      // Bubbles leave the previous payload in place.
      if (up_valid) data_d = up_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RESET_VALUE;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid = valid_q;
  assign data  = data_q;

endmodule

`default_nettype wire

// File: rtl/generic_pipe_staging.sv
// ============================================================================
// Module : generic_pipe_staging
// Valid/ready register pipeline with selectable collapse or global stall.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module generic_pipe_staging
  import generic_pipe_staging_pkg::*;
#(
  parameter int              WIDTH       = 8,
  parameter int              DEPTH       = 2,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter bit              COLLAPSE    = 1'b1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WIDTH-1:0]             out_data,
  output logic [occ_width(DEPTH)-1:0]  occupancy,
  output logic                         empty,
  output logic                         full
);

  localparam int OCC_W = occ_width(DEPTH);

  if (DEPTH <= 0) begin : g_pass
    logic unused_pass;
    assign unused_pass = clk ^ rst_n;
    assign out_valid   = in_valid & ~flush;
    assign in_ready    = out_ready & ~flush;
    assign out_data    = in_data;
    assign occupancy   = '0;
    assign empty       = 1'b1;
    assign full        = 1'b1;
  end else begin : g_pipe
    logic [DEPTH-1:0] v;
    logic [DEPTH-1:0] rdy;
    logic [WIDTH-1:0] d [DEPTH];
    logic             w_adv;
    logic             w_in_ready;
    logic [OCC_W-1:0] w_occ;

    assign w_adv      = ~v[DEPTH-1] | out_ready;
    assign w_in_ready = rdy[0] & ~flush;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             w_up_valid;
      logic [WIDTH-1:0] w_up_data;
      logic             w_down_rdy;

      if (i == 0) begin : g_first
        assign w_up_valid = in_valid & w_in_ready;
        assign w_up_data  = in_data;
      end else begin : g_chain
        assign w_up_valid = v[i-1];
        assign w_up_data  = d[i-1];
      end

      if (i == DEPTH - 1) begin : g_last
        assign w_down_rdy = out_ready;
      end else begin : g_inner
        assign w_down_rdy = rdy[i+1];
      end

      generic_pipe_stage #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE),
        .COLLAPSE    (COLLAPSE)
      ) u_stage (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .adv      (w_adv),
        .down_rdy (w_down_rdy),
        .up_valid (w_up_valid),
        .up_data  (w_up_data),
        .rdy      (rdy[i]),
        .valid    (v[i]),
        .data     (d[i])
      );
    end

    always_comb begin
      w_occ = '0;
      for (int i = 0; i < DEPTH; i++) w_occ = w_occ + OCC_W'(v[i]);
    end

    assign in_ready  = w_in_ready;
    assign out_valid = v[DEPTH-1] & ~flush;
    assign out_data  = d[DEPTH-1];
    assign occupancy = w_occ;
    assign empty     = (w_occ == '0);
    assign full      = (w_occ == OCC_W'(DEPTH));
  end

endmodule

`default_nettype wire

// File: tb/tb_generic_pipe_staging.sv
// ============================================================================
// Module : tb_generic_pipe_staging
// Directed bench over four configurations of generic_pipe_staging.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_generic_pipe_staging;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  // a: DEPTH=3 COLLAPSE=1, b: DEPTH=3 COLLAPSE=0, c: DEPTH=2 RESET=A5, z: DEPTH=0
  logic       a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_empty, a_full;
  logic [7:0] a_in_data, a_out_data;
  logic [1:0] a_occ;
  logic       b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_empty, b_full;
  logic [7:0] b_in_data, b_out_data;
  logic [1:0] b_occ;
  logic       c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_empty, c_full;
  logic [7:0] c_in_data, c_out_data;
  logic [1:0] c_occ;
  logic       z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready, z_empty, z_full;
  logic [7:0] z_in_data, z_out_data;
  logic [0:0] z_occ;

  generic_pipe_staging #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00), .COLLAPSE(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .occupancy(a_occ), .empty(a_empty), .full(a_full));

  generic_pipe_staging #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'h00), .COLLAPSE(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .occupancy(b_occ), .empty(b_empty), .full(b_full));

  generic_pipe_staging #(.WIDTH(8), .DEPTH(2), .RESET_VALUE(8'hA5), .COLLAPSE(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
    .occupancy(c_occ), .empty(c_empty), .full(c_full));

  generic_pipe_staging #(.WIDTH(8), .DEPTH(0), .RESET_VALUE(8'h00), .COLLAPSE(1'b1)) u_z (
    .clk(clk), .rst_n(rst_n), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
    .in_data(z_in_data), .out_valid(z_out_valid), .out_ready(z_out_ready), .out_data(z_out_data),
    .occupancy(z_occ), .empty(z_empty), .full(z_full));

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    #1;
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_a_out_valid got %0h want 0", a_out_valid); end
    n_checks++; if (a_occ !== 2'd0) begin n_fail++; $display("FAIL reset_a_occ got %0d want 0", a_occ); end
    n_checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin n_fail++; $display("FAIL reset_a_empty_full got %b%b want 10", a_empty, a_full); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_a_in_ready got %0h want 1", a_in_ready); end
    n_checks++; if (a_out_data !== 8'h00) begin n_fail++; $display("FAIL reset_a_out_data got %0h want 00", a_out_data); end
    n_checks++; if (c_out_data !== 8'hA5) begin n_fail++; $display("FAIL reset_c_out_data got %0h want a5", c_out_data); end
    n_checks++; if (z_empty !== 1'b1 || z_full !== 1'b1 || z_occ !== 1'b0) begin n_fail++; $display("FAIL reset_z_flags got e=%b f=%b o=%0d want 1 1 0", z_empty, z_full, z_occ); end
  endtask

  task automatic test_latency;
    logic       exp_v;
    logic [7:0] exp_d;
    a_out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      a_in_valid = (i < 3);
      a_in_data  = 8'((i + 1) * 17);
      exp_v      = (i >= 3) && (i <= 5);
      exp_d      = 8'((i - 2) * 17);
      #1;
      n_checks++; if (a_out_valid !== exp_v) begin n_fail++; $display("FAIL latency_valid cyc%0d got %0h want %0h", i, a_out_valid, exp_v); end
      if (exp_v) begin
        n_checks++; if (a_out_data !== exp_d) begin n_fail++; $display("FAIL latency_data cyc%0d got %0h want %0h", i, a_out_data, exp_d); end
      end
      step();
    end
    a_in_valid = 1'b0;
  endtask

  task automatic test_backpressure;
    a_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 8'(8'h41 + i);
      #1;
      n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_accept%0d got %0h want 1", i, a_in_ready); end
      step();
    end
    a_in_data = 8'h44;
    #1;
    n_checks++; if (a_full !== 1'b1 || a_occ !== 2'd3) begin n_fail++; $display("FAIL bp_full got f=%b o=%0d want 1 3", a_full, a_occ); end
    n_checks++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stalled_ready got %0h want 0", a_in_ready); end
    n_checks++; if (a_out_data !== 8'h41) begin n_fail++; $display("FAIL bp_head got %0h want 41", a_out_data); end
    step();
    a_out_ready = 1'b1;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_full_drain_ready got %0h want 1", a_in_ready); end
    step();
    a_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'(8'h42 + i)) begin n_fail++; $display("FAIL bp_drain%0d got v=%0h d=%0h want 1 %0h", i, a_out_valid, a_out_data, 8'(8'h42 + i)); end
      step();
    end
    #1;
    n_checks++; if (a_empty !== 1'b1) begin n_fail++; $display("FAIL bp_empty got %0h want 1", a_empty); end
  endtask

  task automatic test_stall_mode;
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = (i != 1); b_in_valid = (i != 1);
      a_in_data  = (i == 0) ? 8'h51 : 8'h52;
      b_in_data  = a_in_data;
      step();
    end
    a_in_valid = 1'b0; b_in_valid = 1'b0;
    a_out_ready = 1'b0; b_out_ready = 1'b0;
    #1;
    n_checks++; if (b_in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_b_in_ready got %0h want 0", b_in_ready); end
    n_checks++; if (a_in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_a_in_ready got %0h want 1", a_in_ready); end
    n_checks++; if (a_occ !== 2'd2 || b_occ !== 2'd2) begin n_fail++; $display("FAIL stall_occ got a=%0d b=%0d want 2 2", a_occ, b_occ); end
    step();
    a_out_ready = 1'b1; b_out_ready = 1'b1;
    #1;
    n_checks++; if (a_out_data !== 8'h51 || b_out_data !== 8'h51) begin n_fail++; $display("FAIL stall_head got a=%0h b=%0h want 51 51", a_out_data, b_out_data); end
    step();
    #1;
    n_checks++; if (a_out_valid !== 1'b1 || a_out_data !== 8'h52) begin n_fail++; $display("FAIL stall_a_collapsed got v=%0h d=%0h want 1 52", a_out_valid, a_out_data); end
    n_checks++; if (b_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_b_bubble got %0h want 0", b_out_valid); end
    step();
    #1;
    n_checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h52) begin n_fail++; $display("FAIL stall_b_second got v=%0h d=%0h want 1 52", b_out_valid, b_out_data); end
    n_checks++; if (a_out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_a_drained got %0h want 0", a_out_valid); end
    step();
  endtask

  task automatic test_flush;
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_data   = 8'h61;
    step();
    c_in_data = 8'h62;
    step();
    #1;
    n_checks++; if (c_full !== 1'b1 || c_occ !== 2'd2) begin n_fail++; $display("FAIL flush_prefull got f=%b o=%0d want 1 2", c_full, c_occ); end
    c_flush = 1'b1; c_out_ready = 1'b1; c_in_data = 8'h63;
    #1;
    n_checks++; if (c_out_valid !== 1'b0 || c_in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_same_cycle got ov=%0h ir=%0h want 0 0", c_out_valid, c_in_ready); end
    step();
    c_flush = 1'b0; c_in_valid = 1'b0;
    #1;
    n_checks++; if (c_occ !== 2'd0 || c_empty !== 1'b1) begin n_fail++; $display("FAIL flush_cleared got o=%0d e=%b want 0 1", c_occ, c_empty); end
    n_checks++; if (c_out_data !== 8'h61) begin n_fail++; $display("FAIL flush_data_kept got %0h want 61", c_out_data); end
    step();
    step();
    #1;
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_no_emit got %0h want 0", c_out_valid); end
  endtask

  task automatic test_reset_midstream;
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_data   = 8'h71;
    step();
    c_in_data = 8'h72;
    step();
    c_in_valid = 1'b0;
    #1;
    n_checks++; if (c_occ !== 2'd2 || c_out_data !== 8'h71) begin n_fail++; $display("FAIL midrst_pre got o=%0d d=%0h want 2 71", c_occ, c_out_data); end
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    n_checks++; if (c_out_valid !== 1'b0 || c_out_data !== 8'hA5) begin n_fail++; $display("FAIL midrst_post got v=%0h d=%0h want 0 a5", c_out_valid, c_out_data); end
    n_checks++; if (c_occ !== 2'd0 || c_in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_state got o=%0d ir=%0h want 0 1", c_occ, c_in_ready); end
    c_out_ready = 1'b1;
    step();
    #1;
    n_checks++; if (c_out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_no_emit got %0h want 0", c_out_valid); end
  endtask

  task automatic test_passthrough;
    // {in_valid, out_ready, flush, data} -> {out_valid, in_ready}
    logic [10:0] vec [4];
    logic [1:0]  exp  [4];
    vec[0] = {3'b110, 8'h3C}; exp[0] = 2'b11;
    vec[1] = {3'b100, 8'hC3}; exp[1] = 2'b10;
    vec[2] = {3'b111, 8'h5A}; exp[2] = 2'b00;
    vec[3] = {3'b010, 8'h0F}; exp[3] = 2'b01;
    for (int i = 0; i < 4; i++) begin
      {z_in_valid, z_out_ready, z_flush, z_in_data} = vec[i];
      #1;
      n_checks++; if ({z_out_valid, z_in_ready} !== exp[i]) begin n_fail++; $display("FAIL pass_handshake%0d got %b%b want %b", i, z_out_valid, z_in_ready, exp[i]); end
      n_checks++; if (z_out_data !== vec[i][7:0]) begin n_fail++; $display("FAIL pass_data%0d got %0h want %0h", i, z_out_data, vec[i][7:0]); end
    end
    z_flush = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    {a_flush, a_in_valid, a_out_ready, a_in_data} = '0;
    {b_flush, b_in_valid, b_out_ready, b_in_data} = '0;
    {c_flush, c_in_valid, c_out_ready, c_in_data} = '0;
    {z_flush, z_in_valid, z_out_ready, z_in_data} = '0;
    test_reset();
    test_latency();
    test_backpressure();
    test_stall_mode();
    test_flush();
    test_reset_midstream();
    test_passthrough();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
